mem_stage_dmem_ctrl: RTL and testbench
======================================

// Module: mem_stage_dmem_ctrl
// PURPOSE
//  MEM-stage data-memory controller between the EXE/MEM and MEM/WB pipeline registers.
//  - Turns the EXE/MEM load/store request into a req/ready transaction on a wait-state data memory.
//  - Stalls the pipeline until the access completes.
//  - Returns the aligned, sign/zero-extended load word to the MEM/WB register's dmem_rdata input.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max ACCESS cycles without dmem_ready before bus error (1..255)
// PORTS
//  clk              in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  mem_valid        in   1   instruction in MEM is a load/store (from EXE_MEM_reg)
//  mem_op           in   4   {is_store, is_unsigned, size[1:0]}; size 00=byte 01=half 10=word
//  mem_addr         in   32  byte address (ALU result)
//  mem_wdata        in   32  store data (rt)
//  mem_stall        out  1   to PipelineController; freeze PC..EXE_MEM, bubble MEM_WB
//  mem_dmem_rdata   out  32  extended load data to MEM_WB_reg
//  dmem_req         out  1   memory request, held until dmem_ready
//  dmem_we          out  1   1 = write
//  dmem_addr        out  32  word address, bits[1:0]=0
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_be          out  4   byte enables
//  dmem_ready       in   1   access complete; rdata valid when !we
//  dmem_rdata       in   32  raw read word
//  bus_err          out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE, counter 0; every registered output 0. mem_stall=0 while reset is low.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//    - IDLE: mem_valid & aligned -> load dmem_* registers and go to ACCESS.
//    - ACCESS: dmem_req=1 and all dmem_* held stable.
//      - dmem_ready=1: capture extended rdata (loads only; stores leave mem_dmem_rdata unchanged).
//        Clear dmem_* and go to DONE.
//      - Counter reaches TIMEOUT_CYCLES first: bus_err=1 next cycle, mem_dmem_rdata=0, go to DONE.
//    - DONE: one cycle with mem_stall=0 so MEM_WB captures the result and EXE_MEM advances. Then IDLE.
//  - Stall: mem_stall = (IDLE & mem_valid & !misaligned) | ACCESS (combinational).
//  - Latency: minimum 3 cycles per memory op (IDLE, ACCESS with ready, DONE); +1 per wait cycle.
//  - Store lanes:
//    - SB: be = 1 << addr[1:0]; wdata = {4{b}}.
//    - SH: be = addr[1] ? 1100 : 0011; wdata = {2{h}}.
//    - SW: be = 1111.
//  - Loads: select byte/half by addr[1:0]/addr[1]; sign-extend unless is_unsigned.
//  - Illegal size 11: treated as word.
//  - Counter: 8-bit; cleared on entering ACCESS; saturates, never wraps.
//  - dmem_ready outside ACCESS: ignored.
//  - Reset mid-ACCESS: dmem_req drops immediately; the in-flight store may or may not have committed (system-level restart).
//  - mem_valid changes while in ACCESS: ignored. Inputs are sampled only in IDLE.
// CONFIGURATION
//  DMEM_MISALIGN_EXC_EN defined:
//    - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//    - Misaligned op: no memory access, no stall. misalign_exc (extra 1-bit out port) pulses in the IDLE cycle; mem_dmem_rdata <= 0.
//  DMEM_MISALIGN_EXC_EN undefined:
//    - Port absent. Offending low address bits are forced to 0 (half uses addr[1]; word uses lane 0). Access proceeds normally.
// STRUCTURE
//  - Package dmem_pkg:
//    - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
//    - op bit positions OP_STORE/OP_UNSIGNED;
//    - FSM state encodings S_IDLE/S_ACCESS/S_DONE.
//  - Sub-module dmem_load_align: combinational lane select + extension (rdata, addr[1:0], size, unsigned -> 32b).
//  - Top: FSM, counter, store lane logic, output registers.
// TESTING
//  1. LW 0x100, dmem_ready after 2 wait cycles, rdata 0xDEADBEEF
//     -> stall 4 cycles; mem_dmem_rdata=0xDEADBEEF in DONE; dmem_addr=0x100.
//  2. LB 0x103, rdata 0x80112233 -> 0xFFFFFF80. LBU same -> 0x00000080.
//     LH 0x102 -> 0xFFFF8011. LHU 0x100 -> 0x00002233.
//  3. SH 0x102, wdata 0x00001234 -> dmem_we=1, be=1100, dmem_wdata=0x12341234, addr=0x100.
//     mem_dmem_rdata unchanged.
//  4. LW, dmem_ready never asserted, TIMEOUT_CYCLES=4 -> bus_err pulse after 4 ACCESS cycles; rdata=0; FSM returns to IDLE.
//  5. LW 0x102:
//     - with DMEM_MISALIGN_EXC_EN: misalign_exc=1, dmem_req never high, stall 0.
//     - without: dmem_addr=0x100, normal load.
//  6. Reset low during ACCESS -> dmem_req/mem_stall 0 immediately, all outputs 0.
//     After release with mem_valid=0 -> IDLE, no request.

Source files
------------

// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: access size codes,
// mem_op bit positions and FSM state encodings.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // The unused size code 11 behaves as a full word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Wait-state data-memory bus: the controller is the master, the memory the slave.
interface dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_dmem_ctrl_load_align.sv
// Picks the addressed byte/half out of a raw read word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: data = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: turns a pipeline load/store into a req/ready
// transaction, stalls until done, returns extended load data. Option: DMEM_MISALIGN_EXC_EN.
module mem_stage_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic [31:0] mem_dmem_rdata,
    dmem_if.master      dmem,
    output logic        bus_err
`ifdef DMEM_MISALIGN_EXC_EN
    ,
    output logic        misalign_exc
`endif
);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic [1:0]  size_eff;
    logic [1:0]  addr_lo;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // Low address bits that the access actually uses; a half ignores addr[0], a word both.
    always_comb begin
        size_eff = norm_size(mem_op[1:0]);
        case (size_eff)
            SZ_BYTE: addr_lo = mem_addr[1:0];
            SZ_HALF: addr_lo = {mem_addr[1], 1'b0};
            default: addr_lo = 2'b00;
        endcase
`ifdef DMEM_MISALIGN_EXC_EN
        misaligned = (size_eff == SZ_HALF && mem_addr[0]) ||
                     (size_eff == SZ_WORD && mem_addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        case (size_eff)
            SZ_BYTE: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{mem_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = mem_wdata;
            end
        endcase
    end

    dmem_load_align u_load_align (
        .rdata       (dmem.dmem_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_lo_d  = addr_lo_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid && misaligned) begin
                    rdata_d = 32'h0;
                end else if (mem_valid) begin
                    state_d    = S_ACCESS;
                    cnt_d      = 8'h0;
                    req_d      = 1'b1;
                    we_d       = mem_op[OP_STORE];
                    addr_d     = {mem_addr[31:2], 2'b00};
                    wdata_d    = st_wdata;
                    be_d       = st_be;
                    size_d     = size_eff;
                    unsigned_d = mem_op[OP_UNSIGNED];
                    addr_lo_d  = addr_lo;
                end
            end
            S_ACCESS: begin
                if (dmem.dmem_ready || cnt_q >= TIMEOUT_LIMIT) begin
                    if (!dmem.dmem_ready) begin
                        bus_err_d = 1'b1;
                        rdata_d   = 32'h0;
                    end else if (!we_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    be_d    = 4'h0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'h0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            rdata_q    <= 32'h0;
            bus_err_q  <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_lo_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_lo_q  <= addr_lo_d;
        end
    end

    // Reset gates the stall so a held mem_valid cannot freeze the pipeline during reset.
    assign mem_stall = reset && ((state_q == S_IDLE && mem_valid && !misaligned) ||
                                 state_q == S_ACCESS);
`ifdef DMEM_MISALIGN_EXC_EN
    assign misalign_exc = reset && state_q == S_IDLE && mem_valid && misaligned;
`endif

    assign mem_dmem_rdata  = rdata_q;
    assign bus_err         = bus_err_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Scoreboard bench for mem_stage_dmem_ctrl with a wait-state memory responder;
// covers both builds of DMEM_MISALIGN_EXC_EN.
module tb_mem_stage_dmem_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        bus_err;
        int          stalls;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic [31:0] mem_dmem_rdata;
    logic        bus_err;
`ifdef DMEM_MISALIGN_EXC_EN
    logic        misalign_exc;
`endif

    dmem_if bus ();

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        score_q[$];
    logic [31:0] last_rdata = 32'h0;

    int          wait_cfg = 0;
    logic [31:0] word_cfg = 32'h0;
    int          req_cycles = 0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic        unstable = 1'b0;

    mem_stage_dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_op         (mem_op),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_stall      (mem_stall),
        .mem_dmem_rdata (mem_dmem_rdata),
        .dmem           (bus),
        .bus_err        (bus_err)
`ifdef DMEM_MISALIGN_EXC_EN
        ,
        .misalign_exc   (misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder: raises ready after wait_cfg request cycles (never if negative)
    // and records the bus fields of the first request cycle.
    initial begin
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0BAD0BAD;
        forever begin
            @(negedge clk);
            if (bus.dmem_req) begin
                if (req_cycles == 0) begin
                    seen_addr  = bus.dmem_addr;
                    seen_wdata = bus.dmem_wdata;
                    seen_be    = bus.dmem_be;
                    seen_we    = bus.dmem_we;
                    unstable   = 1'b0;
                end else if (bus.dmem_addr !== seen_addr || bus.dmem_wdata !== seen_wdata ||
                             bus.dmem_be !== seen_be || bus.dmem_we !== seen_we) begin
                    unstable = 1'b1;
                end
                bus.dmem_ready = (wait_cfg >= 0) && (req_cycles == wait_cfg);
                bus.dmem_rdata = bus.dmem_ready ? word_cfg : 32'h0BAD0BAD;
                req_cycles++;
            end else begin
                req_cycles     = 0;
                bus.dmem_ready = 1'b0;
                bus.dmem_rdata = 32'h0BAD0BAD;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    // Called just after a falling edge: queues the expectation and presents the op.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int wait_cycles,
                                 input logic [31:0] word, input logic [31:0] exp_rdata,
                                 input logic exp_bus_err, input int exp_stalls,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        e.rdata   = op[3] ? last_rdata : exp_rdata;
        e.bus_err = exp_bus_err;
        e.stalls  = exp_stalls;
        e.we      = op[3];
        e.addr    = {addr[31:2], 2'b00};
        e.be      = exp_be;
        e.wdata   = exp_wdata;
        score_q.push_back(e);
        wait_cfg  = wait_cycles;
        word_cfg  = word;
        mem_op    = op;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_valid = 1'b1;
    endtask

    task automatic collectResult(input string tag);
        exp_t e;
        int   stalls;
        stalls = 0;
        #1;
        for (int i = 0; i < 40 && mem_stall; i++) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_stall_end"}, 32'(mem_stall), 32'd0);
        e = score_q.pop_front();
        checkOutput({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
        checkOutput({tag, "_rdata"}, mem_dmem_rdata, e.rdata);
        checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'(e.bus_err));
        checkOutput({tag, "_addr"}, seen_addr, e.addr);
        checkOutput({tag, "_we"}, 32'(seen_we), 32'(e.we));
        checkOutput({tag, "_stable"}, 32'(unstable), 32'd0);
        if (e.we) begin
            checkOutput({tag, "_be"}, 32'(seen_be), 32'(e.be));
            checkOutput({tag, "_wdata"}, seen_wdata, e.wdata);
        end
        last_rdata = e.rdata;
        mem_valid  = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({tag, "_idle_req"}, 32'(bus.dmem_req), 32'd0);
        checkOutput({tag, "_idle_bus_err"}, 32'(bus_err), 32'd0);
        checkOutput({tag, "_held_rdata"}, mem_dmem_rdata, e.rdata);
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_cycles,
                         input logic [31:0] word, input logic [31:0] exp_rdata,
                         input logic exp_bus_err, input int exp_stalls,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        @(negedge clk);
        applyStimulus(op, addr, wdata, wait_cycles, word, exp_rdata, exp_bus_err,
                      exp_stalls, exp_be, exp_wdata);
        collectResult(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a, w;

        reset     = 1'b0;
        mem_valid = 1'b1;
        mem_op    = 4'b0010;
        mem_addr  = 32'h100;
        mem_wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(mem_stall), 32'd0);
        checkOutput("reset_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("reset_rdata", mem_dmem_rdata, 32'h0);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        runOp("lw_wait2", 4'b0010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4, 4'h0, 32'h0);
        runOp("lb",  4'b0000, 32'h103, 32'h0, 0, 32'h80112233, 32'hFFFFFF80, 1'b0, 2, 4'h0, 32'h0);
        runOp("lbu", 4'b0100, 32'h103, 32'h0, 0, 32'h80112233, 32'h00000080, 1'b0, 2, 4'h0, 32'h0);
        runOp("lh",  4'b0001, 32'h102, 32'h0, 0, 32'h80112233, 32'hFFFF8011, 1'b0, 2, 4'h0, 32'h0);
        runOp("lhu", 4'b0101, 32'h100, 32'h0, 1, 32'h80112233, 32'h00002233, 1'b0, 3, 4'h0, 32'h0);
        runOp("sh",  4'b1001, 32'h102, 32'h00001234, 0, 32'h0, 32'h0, 1'b0, 2, 4'b1100, 32'h12341234);
        runOp("sb",  4'b1000, 32'h101, 32'h000000AB, 0, 32'h0, 32'h0, 1'b0, 2, 4'b0010, 32'hABABABAB);
        runOp("sw",  4'b1010, 32'h104, 32'hCAFEF00D, 1, 32'h0, 32'h0, 1'b0, 3, 4'b1111, 32'hCAFEF00D);
        runOp("size11", 4'b0011, 32'h108, 32'h0, 0, 32'h87654321, 32'h87654321, 1'b0, 2, 4'h0, 32'h0);

`ifdef DMEM_MISALIGN_EXC_EN
        @(negedge clk);
        mem_op    = 4'b0010;
        mem_addr  = 32'h102;
        mem_valid = 1'b1;
        #1;
        checkOutput("mis_exc", 32'(misalign_exc), 32'd1);
        checkOutput("mis_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("mis_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("mis_rdata", mem_dmem_rdata, 32'h0);
        mem_valid = 1'b0;
        last_rdata = 32'h0;
`else
        runOp("lw_mis", 4'b0010, 32'h102, 32'h0, 0, 32'h11223344, 32'h11223344, 1'b0, 2, 4'h0, 32'h0);
        runOp("lh_mis", 4'b0001, 32'h103, 32'h0, 0, 32'h80112233, 32'hFFFF8011, 1'b0, 2, 4'h0, 32'h0);
`endif

        for (int i = 0; i < 6; i++) begin
            sz = 2'($urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            w  = $urandom;
            a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            runOp("rand_ld", {1'b0, u, sz}, a, 32'h0, i % 3, w, modelLoad(w, a[1:0], sz, u),
                  1'b0, 2 + (i % 3), 4'h0, 32'h0);
        end

        runOp("timeout", 4'b0010, 32'h200, 32'h0, -1, 32'h0, 32'h0, 1'b1, 5, 4'h0, 32'h0);
        runOp("lw_after", 4'b0010, 32'h204, 32'h0, 0, 32'h5A5A1234, 32'h5A5A1234, 1'b0, 2, 4'h0, 32'h0);

        @(negedge clk);
        wait_cfg  = -1;
        mem_op    = 4'b0010;
        mem_addr  = 32'h300;
        mem_valid = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_pre_req", 32'(bus.dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_stall", 32'(mem_stall), 32'd0);
        checkOutput("rst_rdata", mem_dmem_rdata, 32'h0);
        checkOutput("rst_addr", bus.dmem_addr, 32'h0);
        checkOutput("rst_be", 32'(bus.dmem_be), 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("post_rst_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("post_rst_stall", 32'(mem_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
